// File: rtl/rdma_rc_sq_psn.sv
// rdma_rc_sq_psn: RC send-queue PSN sequencer.
//
// Issues one packet descriptor per accepted work request, assigns PSNs
// (modulo 2^PSN_WIDTH), bounds the number of unacknowledged packets to
// WIN_DEPTH, retires packets on cumulative ACK and replays from the oldest
// unacknowledged PSN on NAK or ACK timeout. Retry exhaustion pulses
// o_retry_err and parks the sequencer in FAIL until the QP is reset.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   i_qp_state        QP state (RESET=000, INIT=001, RTR=010, RTS=011, ERROR=111)
//   i_qp_ready        QP ready qualifier
//   i_init_psn        starting PSN, sampled on RTS entry
//   i_wr_valid        work request offered / o_wr_ready accepted
//   o_pkt_valid       packet descriptor valid, held until i_pkt_ready
//   o_pkt_psn         PSN of the presented packet
//   o_pkt_retry       presented packet is a replay
//   i_ack_valid       ACK/NAK event, i_ack_nak selects NAK, i_ack_psn its PSN
//   o_outstanding     number of unacknowledged packets
//   o_retry_err       one-cycle pulse on retry exhaustion
module rdma_rc_sq_psn #(
  parameter int PSN_WIDTH   = 24,
  parameter int WIN_DEPTH   = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RETRY_MAX   = 7,
  localparam int OW = $clog2(WIN_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           i_qp_state,
  input  logic                 i_qp_ready,
  input  logic [PSN_WIDTH-1:0] i_init_psn,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic                 o_pkt_valid,
  input  logic                 i_pkt_ready,
  output logic [PSN_WIDTH-1:0] o_pkt_psn,
  output logic                 o_pkt_retry,
  input  logic                 i_ack_valid,
  input  logic                 i_ack_nak,
  input  logic [PSN_WIDTH-1:0] i_ack_psn,
  output logic [OW-1:0]        o_outstanding,
  output logic                 o_retry_err
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_REPLAY = 2'd2;
  localparam logic [1:0] S_FAIL   = 2'd3;

  localparam logic [2:0] QP_RESET = 3'b000;
  localparam logic [2:0] QP_RTS   = 3'b011;

  logic [1:0]           r_state;
  logic                 r_pkt_valid;
  logic [PSN_WIDTH-1:0] r_pkt_psn;
  logic                 r_pkt_retry;
  logic [OW-1:0]        r_outstanding;
  logic                 r_retry_err;
  logic [PSN_WIDTH-1:0] r_next_psn;
  logic [PSN_WIDTH-1:0] r_una_psn;
  logic [PSN_WIDTH-1:0] r_rp_psn;
  logic [TW-1:0]        r_timer;
  logic [RW-1:0]        r_retry_cnt;

  logic                 w_rts_ok;
  logic                 w_active;
  logic                 w_abort;
  logic                 w_slot_free;
  logic                 w_wr_acc;
  logic [PSN_WIDTH-1:0] w_ack_off;
  logic                 w_in_win;
  logic                 w_ack_hit;
  logic                 w_nak_hit;
  logic [OW-1:0]        w_retire;
  logic                 w_timeout;
  logic                 w_issue;
  logic [PSN_WIDTH-1:0] w_rp_adv;
  logic [PSN_WIDTH-1:0] w_rp_dist;
  logic                 w_rp_behind;
  logic [PSN_WIDTH-1:0] w_rp_next;

  assign w_rts_ok    = (i_qp_state == QP_RTS) && i_qp_ready;
  assign w_active    = (r_state == S_RUN) || (r_state == S_REPLAY);
  assign w_abort     = w_active && !w_rts_ok;
  assign w_slot_free = !r_pkt_valid || i_pkt_ready;

  // A WR handshaken in the same cycle as an abort is dropped with the QP.
  assign o_wr_ready = (r_state == S_RUN) && (r_outstanding < OW'(WIN_DEPTH)) && w_slot_free;
  assign w_wr_acc   = i_wr_valid && o_wr_ready && !w_abort;

  // Window membership is the modular distance from the oldest unacked PSN.
  assign w_ack_off = i_ack_psn - r_una_psn;
  assign w_in_win  = w_active && i_ack_valid && (w_ack_off < PSN_WIDTH'(r_outstanding));
  assign w_ack_hit = w_in_win && !i_ack_nak;
  assign w_nak_hit = w_in_win && i_ack_nak;
  // In-window offsets are below o_outstanding, so the low OW bits suffice.
  assign w_retire  = w_ack_hit ? (w_ack_off[OW-1:0] + OW'(1)) :
                     w_nak_hit ?  w_ack_off[OW-1:0] : '0;

  assign w_timeout = (r_state == S_RUN) && (r_outstanding != '0) &&
                     (r_timer == TW'(TIMEOUT_CYC - 1));

  // Replay pointer: advance on issue, snap forward to the new una_psn when a
  // cumulative ACK overtakes it, restart at the NAK PSN on NAK.
  assign w_issue     = (r_state == S_REPLAY) && w_slot_free && (r_rp_psn != r_next_psn);
  assign w_rp_adv    = r_rp_psn + PSN_WIDTH'(w_issue);
  assign w_rp_dist   = w_rp_adv - r_una_psn;
  assign w_rp_behind = w_ack_hit && (w_rp_dist < PSN_WIDTH'(w_retire));
  assign w_rp_next   = w_nak_hit   ? i_ack_psn :
                       w_rp_behind ? (i_ack_psn + PSN_WIDTH'(1)) : w_rp_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pkt_valid   <= 1'b0;
      r_pkt_psn     <= '0;
      r_pkt_retry   <= 1'b0;
      r_outstanding <= '0;
      r_retry_err   <= 1'b0;
      r_next_psn    <= '0;
      r_una_psn     <= '0;
      r_rp_psn      <= '0;
      r_timer       <= '0;
      r_retry_cnt   <= '0;
    end else begin
      r_retry_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pkt_valid <= 1'b0;
          if (w_rts_ok) begin
            r_state       <= S_RUN;
            r_next_psn    <= i_init_psn;
            r_una_psn     <= i_init_psn;
            r_outstanding <= '0;
            r_retry_cnt   <= '0;
            r_timer       <= '0;
          end
        end
        S_RUN, S_REPLAY: begin
          if (w_abort) begin
            r_state       <= S_IDLE;
            r_pkt_valid   <= 1'b0;
            r_outstanding <= '0;
          end else begin
            if (w_wr_acc) begin
              r_pkt_valid <= 1'b1;
              r_pkt_psn   <= r_next_psn;
              r_pkt_retry <= 1'b0;
              r_next_psn  <= r_next_psn + PSN_WIDTH'(1);
            end else if (w_issue) begin
              r_pkt_valid <= 1'b1;
              r_pkt_psn   <= r_rp_psn;
              r_pkt_retry <= 1'b1;
            end else if (i_pkt_ready) begin
              r_pkt_valid <= 1'b0;
            end

            r_outstanding <= r_outstanding + OW'(w_wr_acc) - w_retire;
            if (w_ack_hit) begin
              r_una_psn   <= i_ack_psn + PSN_WIDTH'(1);
              r_retry_cnt <= '0;
            end else if (w_nak_hit) begin
              r_una_psn <= i_ack_psn;
            end
            r_rp_psn <= w_rp_next;

            if (r_state == S_RUN) begin
              // NAK and ACK both take precedence over a coincident timeout.
              if (w_nak_hit) begin
                r_state <= S_REPLAY;
                r_timer <= '0;
              end else if (w_ack_hit) begin
                r_timer <= '0;
              end else if (w_timeout) begin
                r_timer <= '0;
                if (r_retry_cnt == RW'(RETRY_MAX)) begin
                  r_state     <= S_FAIL;
                  r_retry_err <= 1'b1;
                end else begin
                  r_retry_cnt <= r_retry_cnt + RW'(1);
                  r_rp_psn    <= r_una_psn;
                  r_state     <= S_REPLAY;
                end
              end else if (r_outstanding == '0) begin
                r_timer <= '0;
              end else begin
                r_timer <= r_timer + TW'(1);
              end
            end else begin
              r_timer <= '0;
              // Last replayed PSN issued, or everything acknowledged.
              if (!w_nak_hit && (w_rp_next == r_next_psn)) begin
                r_state <= S_RUN;
              end
            end
          end
        end
        default: begin
          r_pkt_valid <= 1'b0;
          if (i_qp_state == QP_RESET) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_pkt_valid   = r_pkt_valid;
  assign o_pkt_psn     = r_pkt_psn;
  assign o_pkt_retry   = r_pkt_retry;
  assign o_outstanding = r_outstanding;
  assign o_retry_err   = r_retry_err;

endmodule

// File: doc/rdma_rc_sq_psn.md
# rdma_rc_sq_psn

- RC send-side PSN sequencer.
- Sits directly downstream of the RC QP state machine. It consumes `qp_state`/`qp_ready` and issues one packet per work request to the packet builder.
- Assigns PSNs, bounds in-flight packets to a window, and retires them on cumulative ACK.
- Replays from the oldest unacknowledged PSN on NAK or timeout, and flags fatal retry exhaustion so the QP can enter ERROR.

## Interface
- `PSN_WIDTH`, 24: PSN width; all PSN arithmetic is modulo 2^PSN_WIDTH.
- `WIN_DEPTH`, 8: maximum outstanding packets, 1..255.
- `TIMEOUT_CYC`, 1024: ACK timeout in clock cycles, ≥2.
- `RETRY_MAX`, 7: number of replays allowed before failure.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `qp_state`  in  3  QP state: RESET=000, INIT=001, RTR=010, RTS=011, ERROR=111.
- `qp_ready`  in  1  QP ready qualifier.
- `init_psn`  in  PSN_WIDTH  starting PSN, sampled on RTS entry.
- `wr_valid`  in  1  work request offered.
- `wr_ready`  out  1  work request accepted when both `wr_valid` and `wr_ready` are high.
- `pkt_valid`  out  1  packet descriptor valid.
- `pkt_ready`  in  1  packet builder accepts.
- `pkt_psn`  out  PSN_WIDTH  PSN of the presented packet.
- `pkt_retry`  out  1  presented packet is a replay.
- `ack_valid`  in  1  ACK/NAK event from the receive path.
- `ack_nak`  in  1  1 = NAK, 0 = ACK.
- `ack_psn`  in  PSN_WIDTH  PSN carried by the ACK/NAK.
- `outstanding`  out  $clog2(WIN_DEPTH+1)  count of unacknowledged packets.
- `retry_err`  out  1  one-cycle pulse on retry exhaustion.

## Operation
- **Reset values:** FSM=IDLE; `wr_ready`=0, `pkt_valid`=0, `pkt_psn`=0, `pkt_retry`=0, `outstanding`=0, `retry_err`=0. Internal state (`next_psn`, `una_psn`, replay pointer, timer, `retry_cnt`) is also 0.
- **Window:** a PSN p is *in window* iff (p − `una_psn`) mod 2^PSN_WIDTH < `outstanding`.
- **FSM states:** IDLE, RUN, REPLAY, FAIL.
- **IDLE**
  - Transition: when `qp_state`==RTS and `qp_ready`=1, go to RUN.
  - On entry to RUN: `next_psn`=`una_psn`=`init_psn`, `outstanding`=0, `retry_cnt`=0, timer=0.
- **RUN**
  - `wr_ready` = (`outstanding` < WIN_DEPTH) && (!`pkt_valid` || `pkt_ready`).
  - Accept action: register `pkt_psn`=`next_psn` and `pkt_retry`=0; `next_psn`+1 (wraps); `outstanding`+1.
- **ACK (any of RUN/REPLAY)**
  - Condition: `ack_psn` in window.
  - Retire n=(`ack_psn`−`una_psn`)+1 packets: `una_psn`=`ack_psn`+1, `outstanding` −= n.
  - Then timer=0 and `retry_cnt`=0.
  - Out-of-window ACKs and NAKs are ignored with no state change.
- **NAK**
  - Condition: `ack_psn` in window.
  - Retire n=(`ack_psn`−`una_psn`): `una_psn`=`ack_psn`.
  - Set replay pointer=`ack_psn`, timer=0, go to REPLAY.
  - A NAK does not consume a retry.
- **Timer**
  - Increments in RUN while `outstanding`>0; held at 0 when `outstanding`=0.
  - When it reaches TIMEOUT_CYC−1:
    - if `retry_cnt`==RETRY_MAX: go to FAIL and pulse `retry_err`;
    - else `retry_cnt`+1, replay pointer=`una_psn`, go to REPLAY.
- **REPLAY**
  - `wr_ready`=0.
  - Presents each PSN from the replay pointer up to `next_psn`−1 with `pkt_retry`=1.
  - If an ACK moves `una_psn` past the replay pointer, the pointer jumps to `una_psn`.
  - When the pointer reaches `next_psn` (or `outstanding` becomes 0): return to RUN with timer=0.
  - A NAK during REPLAY restarts the replay at its PSN.
- **FAIL**
  - `wr_ready`=0. `pkt_valid` is cleared on the next cycle; no further packets.
  - Stays in FAIL until `qp_state`==RESET, then goes to IDLE.
- **Abort:** in RUN or REPLAY, if `qp_state`≠RTS or `qp_ready`=0, the next cycle goes to IDLE. `pkt_valid` is dropped even if not yet accepted, and `outstanding` is cleared.
- **Width rules:**
  - All PSN add/subtract is PSN_WIDTH-bit modulo.
  - `outstanding` never exceeds WIN_DEPTH; the window check prevents underflow.

## Timing
- `wr_ready` is combinational from registered state and `pkt_ready`.
- A WR accepted in cycle N gives `pkt_valid` high at N+1.
- `pkt_valid`, `pkt_psn` and `pkt_retry` are held stable until `pkt_ready`.
- Replay issues one packet per accepted handshake; back-to-back issue is possible when `pkt_ready`=1.
- ACK/NAK is sampled in the cycle `ack_valid`=1; `outstanding` and `una_psn` update at the next edge.
- Simultaneous WR accept and ACK: `outstanding` := `outstanding` + 1 − n. The window check uses the pre-edge `outstanding`.
- Simultaneous timeout and in-window ACK: the ACK wins; timer=0, no replay.
- Simultaneous NAK and timeout: the NAK wins; `retry_cnt` unchanged.
- `retry_err` is high for exactly the one cycle after the FAIL transition edge.
- An asserted `rst_n` forces reset values immediately, including mid-packet.

## Test plan
- **Basic issue and retire:** `init_psn`=0x000010, RTS, 3 WRs with `pkt_ready`=1 → `pkt_psn` 0x10, 0x11, 0x12, each one cycle after accept; `outstanding`=3. ACK psn 0x12 → `outstanding`=0.
- **PSN wrap and window limit:** `init_psn`=0xFFFFFE, 9 WRs offered, no ACK → PSNs FFFFFE, FFFFFF, 000000…000005; `wr_ready`=0 at `outstanding`=8. ACK 0x000000 → `outstanding`=5 and `wr_ready` returns.
- **NAK replay:** 4 outstanding at 0x20–0x23, NAK 0x22 → `outstanding`=2; replays 0x22 and 0x23 with `pkt_retry`=1, then back to RUN. Out-of-window ACK 0x40 → ignored.
- **Timeout exhaustion:** TIMEOUT_CYC=16, RETRY_MAX=2, 1 packet, no ACK → 2 replays spaced 16 cycles apart; third timeout → `retry_err` pulses 1 cycle, FAIL. `qp_state`=RESET → IDLE.
- **Abort:** RTS→ERROR while `pkt_valid`=1 and `pkt_ready`=0 → `pkt_valid`=0 and `outstanding`=0 on the next cycle.
- **Async reset:** `rst_n` low mid-replay → all outputs at reset values.
